front_inst_buffer: RTL
======================

# front_inst_buffer

Decoupling queue between instruction fetch and decode. It accepts instruction pairs in the fetch bundle format: two instructions, two PCs, `is_exception[5:0]` and `exception_cause[5:0][6:0]`. It stores them as individual entries in a circular FIFO and presents up to two oldest entries per cycle to the dual-issue decoder. `exception_flush` from the pipeline controller empties it.

## Interface
Parameters:
- `DEPTH`, 16, number of single-instruction entries; power of two, ≥4.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `exception_flush` in 1: discard all entries.
- `in_valid` in 1: fetch bundle present.
- `in_second` in 1: slot 2 of bundle valid (ignored unless `in_valid`).
- `in_inst_1`, `in_inst_2` in 32: instructions.
- `in_pc_1`, `in_pc_2` in 32: PCs.
- `in_is_exception` in 6: exception flags, copied into each written entry.
- `in_exception_cause` in 42: packed 6×7 causes, copied into each written entry.
- `in_ready` out 1: buffer can take a full pair this cycle.
- `out_valid_1`, `out_valid_2` out 1: head and head+1 entries valid.
- `out_inst_1/2` out 32, `out_pc_1/2` out 32, `out_is_exception_1/2` out 6, `out_exception_cause_1/2` out 42: entry contents.
- `deq_count` in 2: entries consumed by decode this cycle (0, 1, 2).
- `full_cycles` out 32: only with `INST_BUF_STAT_EN`.

## Operation
- State: `head`, `tail` (log2(DEPTH) bits, wrap mod DEPTH) and `count` (log2(DEPTH)+1 bits, 0..DEPTH).
- Enqueue:
  - Fires when `in_valid && in_ready`.
  - Writes `in_*_1` at `tail` and, if `in_second`, `in_*_2` at `tail+1`.
  - `tail` advances by 1 or 2.
- Dequeue:
  - Effective amount is `min(deq_count, count)`; any excess is ignored.
  - `head` advances by that amount.
- `count_next = count + enq_n − deq_n`. Simultaneous enqueue and dequeue is legal in any combination.
- `in_ready = (DEPTH − count) ≥ 2`, computed from the registered count. Same-cycle dequeue is not credited.
- Outputs are combinational from storage at `head` / `head+1`:
  - `out_valid_1 = count≥1 && !exception_flush`.
  - `out_valid_2 = count≥2 && !exception_flush`.
  - Data ports are driven 0 when the corresponding valid is low.
- Flush has the highest priority:
  - In the flush cycle, enqueue and dequeue are ignored.
  - Next cycle: `head = tail = count = 0`.
  - `in_ready` stays asserted during the flush cycle; the bundle presented is dropped.
- Entry storage is not reset; only pointers and count are.

## Timing
- Reset values: `head = tail = count = 0`; `in_ready = 1`; all `out_valid_* = 0`; all output data 0; `full_cycles = 0`.
- Latency: an entry written in cycle N is visible on the outputs in cycle N+1. There is no empty-bypass.
- Order: entries are presented strictly in enqueue order. Slot 1 of a pair always precedes slot 2.
- Wrap: writes at `tail = DEPTH−1` with `in_second` place slot 2 at index 0.
- Full boundary:
  - At `count = DEPTH−1`, `in_ready = 0` even if a single-slot bundle is offered.
  - At `count = DEPTH−2`, a pair is accepted and `count` becomes DEPTH.
- Empty boundary: `deq_count = 2` with `count = 1` removes one entry; `count` becomes 0.
- Reset mid-operation: all state clears immediately and asynchronously, and the outputs invalidate in the same cycle.

## Configuration
- `INST_BUF_STAT_EN`:
  - When defined, adds the `full_cycles` port: a 32-bit counter that increments every cycle with `count == DEPTH`. It saturates at 0xFFFFFFFF, resets to 0 and is not cleared by flush.
  - When undefined, the port and counter do not exist. All other behaviour is identical.

## Test plan
- Reset, then `in_valid=1`, `in_second=1`, `inst=0x11/0x22`, `pc=0x1c000000/0x1c000004`. Required: outputs invalid in that cycle; next cycle `out_valid_1/2=1` with those values, `count=2`.
- Fill to 16 with 8 pairs and no dequeue. Required: `in_ready=0` at `count=16`; a ninth bundle is not written; with `INST_BUF_STAT_EN`, `full_cycles` increments by 1 per held cycle.
- Start at `count=15`, `in_valid=1`, `in_second=0`. Required: `in_ready=0` and `count` stays 15. Then `deq_count=2`. Required: `count=13` and `in_ready=1`.
- Start at `head=tail=15`, empty, and enqueue the pair `0xA/0xB`. Required: `0xA` stored at index 15, `0xB` at index 0; outputs `0xA` then `0xB`; `tail=1`.
- Start at `count=1`, `deq_count=2`, and simultaneously enqueue a pair. Required: `count=2` next cycle, with the new pair at the head.
- Start at `count=6`, `exception_flush=1` with a concurrent valid bundle and `deq_count=2`. Required: `out_valid_*=0` in that cycle; next cycle `count=0` and `in_ready=1`, with nothing of the dropped bundle visible.

Source files
------------

// File: rtl/front_inst_buffer.sv
// -----------------------------------------------------------------------------
// front_inst_buffer
//   Decoupling FIFO between instruction fetch and the dual-issue decoder.
//   Fetch delivers bundles of up to two instructions; each instruction becomes
//   one entry of a circular buffer. The two oldest entries are presented to
//   decode every cycle, and decode reports how many it consumed (0..2).
//   exception_flush empties the buffer and overrides enqueue/dequeue.
//
//   Optional feature: define INST_BUF_STAT_EN to add the full_cycles counter.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   exception_flush          discard all entries (highest priority)
//   in_valid, in_second      bundle present / slot 2 of bundle valid
//   in_inst_1/2, in_pc_1/2   instruction words and PCs of the bundle
//   in_is_exception          exception flags copied into each written entry
//   in_exception_cause       packed 6x7 causes copied into each written entry
//   in_ready                 a full pair can be accepted this cycle
//   out_valid_1/2            head / head+1 entry valid
//   out_inst_*, out_pc_*, out_is_exception_*, out_exception_cause_*
//                            entry contents, zero when the lane is invalid
//   deq_count                entries consumed by decode this cycle
//   full_cycles              (INST_BUF_STAT_EN) cycles spent full, saturating
// -----------------------------------------------------------------------------
module front_inst_buffer #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exception_flush,
    input  logic        in_valid,
    input  logic        in_second,
    input  logic [31:0] in_inst_1,
    input  logic [31:0] in_inst_2,
    input  logic [31:0] in_pc_1,
    input  logic [31:0] in_pc_2,
    input  logic [5:0]  in_is_exception,
    input  logic [41:0] in_exception_cause,
    output logic        in_ready,
    output logic        out_valid_1,
    output logic        out_valid_2,
    output logic [31:0] out_inst_1,
    output logic [31:0] out_inst_2,
    output logic [31:0] out_pc_1,
    output logic [31:0] out_pc_2,
    output logic [5:0]  out_is_exception_1,
    output logic [5:0]  out_is_exception_2,
    output logic [41:0] out_exception_cause_1,
    output logic [41:0] out_exception_cause_2,
    input  logic [1:0]  deq_count
`ifdef INST_BUF_STAT_EN
    ,
    output logic [31:0] full_cycles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [5:0]  is_exc;
        logic [41:0] cause;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;

    logic          enq_fire;
    logic [CW-1:0] enq_n, deq_n;
    logic [1:0]    deq_req;
    entry_t        wr_1, wr_2;

    // Readiness uses the registered count only; a same-cycle dequeue does
    // not open room for the incoming pair.
    assign in_ready = (DEPTH_C - count) >= CW'(2);
    assign enq_fire = in_valid && in_ready && !exception_flush;
    assign enq_n    = enq_fire ? (in_second ? CW'(2) : CW'(1)) : '0;

    // Only two entries are ever presented, so an out-of-range request of 3
    // is treated as 2; then never remove more than is held.
    assign deq_req = (deq_count > 2'd2) ? 2'd2 : deq_count;
    assign deq_n   = (CW'(deq_req) > count) ? count : CW'(deq_req);

    assign wr_1 = '{inst: in_inst_1, pc: in_pc_1, is_exc: in_is_exception, cause: in_exception_cause};
    assign wr_2 = '{inst: in_inst_2, pc: in_pc_2, is_exc: in_is_exception, cause: in_exception_cause};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (exception_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + deq_n[AW-1:0];
            tail  <= tail + enq_n[AW-1:0];
            count <= count + enq_n - deq_n;
        end
    end

    // Storage carries no reset; validity is tracked by head/count alone.
    // tail + 1 wraps naturally in AW bits.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[tail] <= wr_1;
            if (in_second)
                mem[tail + AW'(1)] <= wr_2;
        end
    end

    // Read lanes: lane g shows entry head+g when at least g+1 entries exist.
    logic [1:0] lane_valid;
    entry_t     lane_data [2];

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [AW-1:0] idx;
        assign idx           = head + AW'(g);
        assign lane_valid[g] = (count > CW'(g)) && !exception_flush;
        assign lane_data[g]  = lane_valid[g] ? mem[idx] : '0;
    end

    assign out_valid_1           = lane_valid[0];
    assign out_valid_2           = lane_valid[1];
    assign out_inst_1            = lane_data[0].inst;
    assign out_inst_2            = lane_data[1].inst;
    assign out_pc_1              = lane_data[0].pc;
    assign out_pc_2              = lane_data[1].pc;
    assign out_is_exception_1    = lane_data[0].is_exc;
    assign out_is_exception_2    = lane_data[1].is_exc;
    assign out_exception_cause_1 = lane_data[0].cause;
    assign out_exception_cause_2 = lane_data[1].cause;

`ifdef INST_BUF_STAT_EN
    // Counts cycles that begin full; saturates and survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            full_cycles <= '0;
        else if (count == DEPTH_C && full_cycles != 32'hFFFF_FFFF)
            full_cycles <= full_cycles + 32'd1;
    end
`endif

endmodule
